// File: rtl/signal_ramp_scaler.sv
// signal_ramp_scaler
//   Scales each signed DAC sample by the ramp envelope coming from the signal
//   ramper: out = (sample * ramp) >> RAMP_BITS, where ramp == 2**RAMP_BITS is
//   unity gain. Three-stage pipeline with no backpressure. Also tracks ramp-down
//   progress for the sequence/status registers:
//     rampDownCount - valid output samples seen in the ramp-down state (saturating)
//     rampDonePulse - one cycle on the first valid output sample of a "done" run
//     rampDone      - sticky copy of the pulse, cleared by clearDone
//
//   Build option: define SIGNAL_RAMP_SCALER_ROUND_EN to round half up before the
//   shift instead of truncating toward -inf. Latency is 3 cycles either way.

module signal_ramp_scaler #(
  parameter int DATA_WIDTH  = 16,
  parameter int RAMP_BITS   = 13,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic signed [DATA_WIDTH-1:0]  s_axis_tdata_signal,
  input  logic                          s_axis_tvalid_signal,
  input  logic        [15:0]            ramp,
  input  logic        [1:0]             rampState,
  input  logic                          clearDone,
  output logic signed [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          rampDone,
  output logic                          rampDonePulse,
  output logic        [COUNT_WIDTH-1:0] rampDownCount
);

  // Ramper state encoding as driven by the upstream block.
  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_DONE   = 2'b01,
    ST_UP     = 2'b10,
    ST_DOWN   = 2'b11
  } ramp_state_e;

  // Clamped ramp needs one bit above RAMP_BITS to hold exact unity.
  localparam int RAMP_W = RAMP_BITS + 1;
  // Signed product of a DATA_WIDTH sample and a zero-extended RAMP_W ramp.
  localparam int PROD_W = DATA_WIDTH + RAMP_BITS + 1;
  // One guard bit so the rounding constant can never overflow the product.
  localparam int SUM_W  = PROD_W + 1;
  // Width of the bits above the output's sign bit after the shift, inclusive.
  localparam int HI_W   = SUM_W - DATA_WIDTH + 1;

  localparam logic [15:0] UNITY = 16'(1) << RAMP_BITS;

`ifdef SIGNAL_RAMP_SCALER_ROUND_EN
  localparam logic signed [SUM_W-1:0] ROUND_ADD = SUM_W'(2 ** (RAMP_BITS - 1));
`else
  localparam logic signed [SUM_W-1:0] ROUND_ADD = '0;
`endif

  localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic        [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Stage 1: capture sample, valid, state and clamped ramp
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] s1_data;
  logic                         s1_valid;
  ramp_state_e                  s1_state;
  logic        [RAMP_W-1:0]     s1_ramp;
  logic        [RAMP_W-1:0]     ramp_clamped;

  // Clamp the ramp to unity so the product can never exceed the input magnitude.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves the
    // variable unassigned; otherwise synthesis infers a latch.
    ramp_clamped = ramp[RAMP_W-1:0];
    if (ramp > UNITY) begin
      ramp_clamped = UNITY[RAMP_W-1:0];
    end
  end

  // Stage 1 registers; data registers update every cycle, valid qualifies them.
  always_ff @(posedge clk or negedge aresetn) begin
    // NOTE: the data path is reset as well as the control bits so that an
    // asynchronous reset mid-stream leaves no stale sample visible anywhere.
    if (!aresetn) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_state <= ST_NORMAL;
      s1_ramp  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register in the pipeline
      // sample the pre-edge value, independent of statement order.
      s1_data  <= s_axis_tdata_signal;
      s1_valid <= s_axis_tvalid_signal;
      s1_state <= ramp_state_e'(rampState);
      s1_ramp  <= ramp_clamped;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: signed multiply, ramp zero-extended
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] data_ext;
  logic signed [PROD_W-1:0] ramp_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] s2_prod;
  logic                     s2_valid;
  ramp_state_e              s2_state;

  // The ramp is a magnitude: widen it as unsigned, then treat it as a positive signed value.
  assign data_ext = PROD_W'(s1_data);
  assign ramp_ext = $signed(PROD_W'(s1_ramp));
  assign product  = data_ext * ramp_ext;

  // Stage 2 registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s2_prod  <= '0;
      s2_valid <= 1'b0;
      s2_state <= ST_NORMAL;
    end else begin
      s2_prod  <= product;
      s2_valid <= s1_valid;
      s2_state <= s1_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: optional rounding, arithmetic shift, saturation
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0]      sum;
  logic signed [SUM_W-1:0]      shifted;
  logic        [HI_W-1:0]       hi_bits;
  logic                         overflow;
  logic signed [DATA_WIDTH-1:0] sat_data;

  assign sum      = SUM_W'(s2_prod) + ROUND_ADD;
  assign shifted  = sum >>> RAMP_BITS;
  // The result fits when every bit from the output sign bit upward agrees.
  assign hi_bits  = shifted[SUM_W-1:DATA_WIDTH-1];
  assign overflow = !((&hi_bits) || !(|hi_bits));

  // Saturate toward the sign of the shifted value; with a clamped ramp this is a guard only.
  always_comb begin
    sat_data = shifted[DATA_WIDTH-1:0];
    if (overflow) begin
      sat_data = shifted[SUM_W-1] ? DATA_MIN : DATA_MAX;
    end
  end

  // Output data and valid registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      m_axis_tdata  <= sat_data;
      m_axis_tvalid <= s2_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Status, evaluated on the sample leaving stage 3
  // ---------------------------------------------------------------------------
  ramp_state_e prev_state;
  logic        enter_done;
  logic        count_inc;

  // A done run starts on the first valid done-state sample after any other state.
  assign enter_done = s2_valid && (s2_state == ST_DONE) && (prev_state != ST_DONE);
  assign count_inc  = s2_valid && (s2_state == ST_DOWN) && (rampDownCount != COUNT_MAX);

  // Remember the state of the last valid sample; invalid cycles leave it alone.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prev_state <= ST_NORMAL;
    end else if (s2_valid) begin
      prev_state <= s2_state;
    end
  end

  // Done pulse and sticky flag; a new done entry wins over a simultaneous clear.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rampDonePulse <= 1'b0;
      rampDone      <= 1'b0;
    end else begin
      rampDonePulse <= enter_done;
      if (enter_done) begin
        rampDone <= 1'b1;
      end else if (clearDone) begin
        rampDone <= 1'b0;
      end
    end
  end

  // Saturating ramp-down sample counter; clear takes priority over counting.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rampDownCount <= '0;
    end else if (clearDone) begin
      rampDownCount <= '0;
    end else if (count_inc) begin
      rampDownCount <= rampDownCount + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_signal_ramp_scaler.sv
// tb_signal_ramp_scaler
//   Self-checking bench for signal_ramp_scaler. Expected samples are queued when
//   stimulus is driven and compared when they are due at the output; status
//   outputs are compared every cycle against a small behavioural model.

module tb_signal_ramp_scaler;

`ifdef SIGNAL_RAMP_SCALER_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               aresetn = 1'b1;
  logic signed [15:0] s_axis_tdata_signal = '0;
  logic               s_axis_tvalid_signal = 1'b0;
  logic        [15:0] ramp = '0;
  logic        [1:0]  rampState = 2'b00;
  logic               clearDone = 1'b0;
  logic signed [15:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               rampDone;
  logic               rampDonePulse;
  logic        [31:0] rampDownCount;

  always #5 clk = ~clk;

  signal_ramp_scaler dut (
    .clk                  (clk),
    .aresetn              (aresetn),
    .s_axis_tdata_signal  (s_axis_tdata_signal),
    .s_axis_tvalid_signal (s_axis_tvalid_signal),
    .ramp                 (ramp),
    .rampState            (rampState),
    .clearDone            (clearDone),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tvalid        (m_axis_tvalid),
    .rampDone             (rampDone),
    .rampDonePulse        (rampDonePulse),
    .rampDownCount        (rampDownCount)
  );

  typedef struct {
    logic signed [15:0] data;
    logic        [1:0]  state;
    int                 due;
  } exp_t;

  typedef struct {
    logic signed [15:0] s;
    logic        [15:0] r;
    logic signed [15:0] e;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[14];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          pulses_seen = 0;
  int          last_pulse_cyc = -1;
  int          first01_cyc;
  int          pulses_before;
  logic [31:0] m_count = '0;
  logic        m_done = 1'b0;
  logic [1:0]  m_prev = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference scaling: clamp, exact product, optional half-up rounding, floor, saturate.
  function automatic logic signed [15:0] model(input logic signed [15:0] s, input logic [15:0] r);
    longint rc;
    longint p;
    rc = (r > 16'd8192) ? 64'sd8192 : longint'(r);
    p  = longint'(s) * rc;
    if (ROUND) p = p + 4096;
    p = p >>> 13;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  task automatic drive(input logic v, input logic signed [15:0] s, input logic [15:0] r,
                       input logic [1:0] st, input logic signed [15:0] exp);
    s_axis_tvalid_signal = v;
    s_axis_tdata_signal  = s;
    ramp                 = r;
    rampState            = st;
    if (v && aresetn) sb.push_back('{data: exp, state: st, due: cyc + 3});
  endtask

  task automatic drive_m(input logic v, input logic signed [15:0] s, input logic [15:0] r,
                         input logic [1:0] st);
    drive(v, s, r, st, model(s, r));
  endtask

  // One clock: advance, then compare everything the model says is due this cycle.
  task automatic step();
    logic clr;
    exp_t e;
    logic exp_valid;
    logic exp_pulse;
    clr = clearDone;
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 1'b0;
    exp_pulse = 1'b0;
    if (aresetn && sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_valid = 1'b1;
    end
    if (exp_valid) begin
      if (e.state == 2'b11 && m_count != '1) m_count++;
      if (e.state == 2'b01 && m_prev != 2'b01) exp_pulse = 1'b1;
      m_prev = e.state;
    end
    if (aresetn && clr) m_count = '0;
    if (exp_pulse) m_done = 1'b1;
    else if (aresetn && clr) m_done = 1'b0;
    check("tvalid", m_axis_tvalid, exp_valid);
    if (exp_valid) check("tdata", m_axis_tdata, e.data);
    check("pulse", rampDonePulse, exp_pulse);
    check("done", rampDone, m_done);
    check("count", rampDownCount, m_count);
    if (rampDonePulse) begin
      pulses_seen++;
      last_pulse_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 16'd0, 2'b00, '0);
      step();
    end
  endtask

  task automatic reset_assert();
    aresetn = 1'b0;
    #1;
    sb.delete();
    m_count = '0;
    m_done  = 1'b0;
    m_prev  = 2'b00;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 16'd0);
    check("rst_done", rampDone, 1'b0);
    check("rst_pulse", rampDonePulse, 1'b0);
    check("rst_count", rampDownCount, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{16'sd1000,   16'd4096,  16'sd500};
    vecs[1]  = '{-16'sd1001,  16'd4096,  ROUND ? -16'sd500 : -16'sd501};
    vecs[2]  = '{16'sd3,      16'd1,     16'sd0};
    vecs[3]  = '{16'sd32767,  16'd8192,  16'sd32767};
    vecs[4]  = '{-16'sd32768, 16'd8192,  -16'sd32768};
    vecs[5]  = '{16'sd32767,  16'd65535, 16'sd32767};
    vecs[6]  = '{-16'sd32768, 16'd65535, -16'sd32768};
    vecs[7]  = '{-16'sd1,     16'd8192,  -16'sd1};
    vecs[8]  = '{-16'sd1,     16'd4096,  ROUND ? 16'sd0 : -16'sd1};
    vecs[9]  = '{16'sd1234,   16'd0,     16'sd0};
    vecs[10] = '{16'sd12345,  16'd9000,  16'sd12345};
    vecs[11] = '{16'sd100,    16'd8191,  ROUND ? 16'sd100 : 16'sd99};
    vecs[12] = '{-16'sd100,   16'd8191,  -16'sd100};
    vecs[13] = '{16'sd5,      16'd6554,  16'sd4};

    // Reset with valid held high: nothing valid comes out during or just after reset.
    s_axis_tvalid_signal = 1'b1;
    #2;
    reset_assert();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'sd111, 16'd8192, 2'b00, 16'sd111);
      step();
    end
    aresetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 16'(i * 2731 - 15000), 16'd8192, 2'b00, 16'(i * 2731 - 15000));
      step();
    end
    idle(4);

    // Arithmetic vectors, back to back.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].s, vecs[i].r, 2'b00, vecs[i].e);
      step();
    end
    idle(4);

    // Random samples and ramps with gaps in valid.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 9) == 0) ? 16'd65535 : 16'($urandom_range(0, 9000));
      drive_m(($urandom_range(0, 3) != 0), 16'($urandom), r, 2'b00);
      step();
    end
    idle(4);

    // Full ramp sequence: up, normal, 8192 down samples with invalid gaps, then done.
    pulses_seen = 0;
    for (int i = 0; i < 5; i++) begin drive_m(1'b1, 16'sd20000, 16'(i * 2000), 2'b10); step(); end
    for (int i = 0; i < 5; i++) begin drive_m(1'b1, 16'sd20000, 16'd8192, 2'b00); step(); end
    for (int i = 0; i < 8192; i++) begin
      if (i % 1000 == 500) begin
        drive(1'b0, '0, 16'd0, 2'b01, '0);
        step();
      end
      drive_m(1'b1, 16'sd20000, 16'(8192 - i), 2'b11);
      step();
    end
    first01_cyc = cyc;
    for (int i = 0; i < 12; i++) begin drive_m(1'b1, 16'sd20000, 16'd0, 2'b01); step(); end
    idle(4);
    check("down_count", rampDownCount, 32'd8192);
    check("pulse_count", pulses_seen, 1);
    check("pulse_latency", last_pulse_cyc, first01_cyc + 3);
    check("done_sticky", rampDone, 1'b1);

    // clearDone together with a new done entry: set wins, count clears.
    for (int i = 0; i < 3; i++) begin drive_m(1'b1, 16'sd7, 16'd8192, 2'b00); step(); end
    idle(4);
    check("count_held", rampDownCount, 32'd8192);
    drive_m(1'b1, 16'sd7, 16'd0, 2'b01);
    step();
    drive(1'b0, '0, 16'd0, 2'b00, '0);
    step();
    clearDone = 1'b1;
    step();
    clearDone = 1'b0;
    check("clr_set_done", rampDone, 1'b1);
    check("clr_set_pulse", rampDonePulse, 1'b1);
    check("clr_set_count", rampDownCount, 32'd0);
    idle(3);

    // clearDone alone clears both.
    for (int i = 0; i < 3; i++) begin drive_m(1'b1, 16'sd9, 16'd8192, 2'b11); step(); end
    idle(4);
    check("count_three", rampDownCount, 32'd3);
    clearDone = 1'b1;
    step();
    clearDone = 1'b0;
    check("clr_done", rampDone, 1'b0);
    check("clr_count", rampDownCount, 32'd0);

    // Two ramp-downs without a clear: counts accumulate, a pulse per done entry.
    pulses_before = pulses_seen;
    for (int i = 0; i < 5; i++) begin drive_m(1'b1, 16'sd1, 16'd8192, 2'b11); step(); end
    for (int i = 0; i < 2; i++) begin drive_m(1'b1, 16'sd1, 16'd8192, 2'b01); step(); end
    for (int i = 0; i < 3; i++) begin drive_m(1'b1, 16'sd1, 16'd8192, 2'b11); step(); end
    for (int i = 0; i < 2; i++) begin drive_m(1'b1, 16'sd1, 16'd8192, 2'b01); step(); end
    idle(4);
    check("accum_count", rampDownCount, 32'd8);
    check("accum_pulses", pulses_seen - pulses_before, 2);
    check("accum_done", rampDone, 1'b1);

    // Reset mid ramp-down with three samples in flight.
    for (int i = 0; i < 6; i++) begin drive_m(1'b1, 16'sd4000, 16'd4096, 2'b11); step(); end
    drive_m(1'b1, 16'sd4000, 16'd4096, 2'b11);
    #2;
    reset_assert();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'sd4000, 16'd4096, 2'b11, 16'sd2000);
      step();
    end
    aresetn = 1'b1;
    idle(4);
    drive_m(1'b1, -16'sd4000, 16'd4096, 2'b11);
    step();
    idle(5);
    check("post_rst_count", rampDownCount, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
